instr_encoder: RTL and testbench

Encodes structured instruction requests into 32-bit MIPS instruction words and writes them, big-endian and byte-serial, into the byte-wide instruction memory. Its opcode map is exactly the one the main control decoder consumes, so the two blocks stay in step. The block is used by test harnesses and the boot loader to fill instruction memory, one word per accepted request, with no external assembler.

---
 rtl/instr_encoder.sv | 172 +++++++++++++++++
 tb/tb_instr_encoder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Encodes instruction requests (R, lw, sw, beq, j, addi, andi,
//             ori, slti) into 32-bit MIPS words. Each word is written MSB
//             first, one byte per cycle, into a byte-wide instruction memory.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             in_valid/in_ready   - request handshake
//             in_kind..in_target  - instruction fields
//             addr_clr            - rewind write pointer, clear status (IDLE)
//             mem_we/addr/wdata   - byte write port
//             word_count, full,   - words written, pointer wrapped,
//             err                 - sticky illegal-kind flag
//  Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              addr_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-2:0] word_count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);

  // Opcode map shared with the main control decoder
  localparam logic [5:0] c_op_r    = 6'b000000;
  localparam logic [5:0] c_op_lw   = 6'b100011;
  localparam logic [5:0] c_op_sw   = 6'b101011;
  localparam logic [5:0] c_op_beq  = 6'b000100;
  localparam logic [5:0] c_op_j    = 6'b000010;
  localparam logic [5:0] c_op_addi = 6'b001000;
  localparam logic [5:0] c_op_andi = 6'b001100;
  localparam logic [5:0] c_op_ori  = 6'b001101;
  localparam logic [5:0] c_op_slti = 6'b001010;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    WR1  = 3'd2,
    WR2  = 3'd3,
    WR3  = 3'd4
  } state_t;

  state_t              state_q;
  logic [31:0]         word_q;
  logic [31:0]         word_d;
  logic                kind_legal;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   ptr_d;
  logic [ADDR_W-2:0]   count_q;
  logic                full_q;
  logic                err_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;

  // Field packing per instruction kind; unused fields are simply dropped
  always_comb begin
    word_d     = 32'h0;
    kind_legal = 1'b1;
    case (in_kind)
      4'd0:    word_d = {c_op_r, in_rs, in_rt, in_rd, in_shamt, in_funct};
      4'd1:    word_d = {c_op_lw,   in_rs, in_rt, in_imm};
      4'd2:    word_d = {c_op_sw,   in_rs, in_rt, in_imm};
      4'd3:    word_d = {c_op_beq,  in_rs, in_rt, in_imm};
      4'd4:    word_d = {c_op_j, in_target};
      4'd5:    word_d = {c_op_addi, in_rs, in_rt, in_imm};
      4'd6:    word_d = {c_op_andi, in_rs, in_rt, in_imm};
      4'd7:    word_d = {c_op_ori,  in_rs, in_rt, in_imm};
      4'd8:    word_d = {c_op_slti, in_rs, in_rt, in_imm};
      default: kind_legal = 1'b0;
    endcase
  end

  assign ptr_d = ptr_q + ADDR_W'(4);

  // addr_clr blocks the handshake in the same cycle so a clear never races
  // with a new word being latched.
  assign in_ready = (state_q == IDLE) && !full_q && !addr_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= 32'h0;
      ptr_q       <= c_base;
      count_q     <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= c_base;
      mem_wdata_q <= 8'h0;
    end else begin
      case (state_q)
        IDLE: begin
          mem_we_q <= 1'b0;
          if (addr_clr) begin
            ptr_q   <= c_base;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
          end else if (in_valid && in_ready) begin
            if (kind_legal) begin
              word_q      <= word_d;
              state_q     <= WR0;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= ptr_q;
              mem_wdata_q <= word_d[31:24];
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        WR0: begin
          state_q     <= WR1;
          mem_addr_q  <= ptr_q + ADDR_W'(1);
          mem_wdata_q <= word_q[23:16];
        end
        WR1: begin
          state_q     <= WR2;
          mem_addr_q  <= ptr_q + ADDR_W'(2);
          mem_wdata_q <= word_q[15:8];
        end
        WR2: begin
          state_q     <= WR3;
          mem_addr_q  <= ptr_q + ADDR_W'(3);
          mem_wdata_q <= word_q[7:0];
        end
        WR3: begin
          state_q  <= IDLE;
          mem_we_q <= 1'b0;
          ptr_q    <= ptr_d;
          count_q  <= count_q + 1'b1;
          // A wrap back to address 0 means every slot has been used
          if (ptr_d == '0) begin
            full_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = count_q;
  assign full       = full_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Purpose  : Directed self-checking bench for instr_encoder (ADDR_W=8,
//             BASE_ADDR=0). Inputs change 1 ns after the rising edge and
//             outputs are sampled at that same point.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        addr_clr;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [6:0]  word_count;
  logic        full;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_shamt   (in_shamt),
    .in_funct   (in_funct),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .addr_clr   (addr_clr),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .word_count (word_count),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                            input logic [15:0] imm, input logic [25:0] tg);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tg;
  endtask

  // Raise in_valid, wait (bounded) for in_ready, take the handshake edge.
  task automatic handshake();
    int waited = 0;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Record four write cycles starting in WR0; ends in the first IDLE cycle.
  task automatic capture_word(output logic [31:0] w, output logic [7:0] a0,
                              output int we_cnt, output bit contig);
    w = 32'h0; a0 = mem_addr; we_cnt = 0; contig = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (mem_we === 1'b1) we_cnt++;
      if (mem_addr !== a0 + 8'(i)) contig = 1'b0;
      w = {w[23:0], mem_wdata};
      tick();
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; addr_clr = 1'b0;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; addr_clr = 1'b0;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    #2;
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, word_count, full, err} !== {1'b0, 8'h00, 8'h00, 7'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b addr=%h data=%h cnt=%0d full=%b err=%b, required all zero",
               mem_we, mem_addr, mem_wdata, word_count, full, err);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_addi();
    logic [31:0] w; logic [7:0] a0; int we; bit ct;
    do_reset();
    set_fields(4'd5, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3f, 16'h0005, 26'h3ffffff);
    handshake();
    capture_word(w, a0, we, ct);
    n_checks++;
    if ({w, a0, we[2:0], ct} !== {32'h20080005, 8'h00, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL addi_word: word=%h addr0=%h we_cycles=%0d contig=%b, required 20080005 00 4 1", w, a0, we, ct);
    end
    n_checks++;
    if ({mem_we, word_count} !== {1'b0, 7'd1}) begin
      n_fail++;
      $display("FAIL addi_count: we=%b cnt=%0d, required we=0 cnt=1", mem_we, word_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w; logic [7:0] a0; int we; bit ct;
    do_reset();
    set_fields(4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'hbeef, 26'h1234567);
    handshake();
    in_valid = 1'b1;
    set_fields(4'd2, 5'd29, 5'd9, 5'd7, 5'd3, 6'h11, 16'h0008, 26'h0abcdef);
    capture_word(w, a0, we, ct);
    n_checks++;
    if ({w, a0, we[2:0], ct} !== {32'h01095020, 8'h00, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_rtype: word=%h addr0=%h we_cycles=%0d contig=%b, required 01095020 00 4 1", w, a0, we, ct);
    end
    // Fifth cycle after the first handshake: must accept immediately
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_5th: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    capture_word(w, a0, we, ct);
    n_checks++;
    if ({w, a0, we[2:0], ct} !== {32'hAFA90008, 8'h04, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_sw: word=%h addr0=%h we_cycles=%0d contig=%b, required afa90008 04 4 1", w, a0, we, ct);
    end
  endtask

  task automatic test_kinds();
    logic [3:0]  kinds [5] = '{4'd1, 4'd3, 4'd6, 4'd7, 4'd8};
    logic [4:0]  rss   [5] = '{5'd1, 5'd1, 5'd3, 5'd3, 5'd5};
    logic [4:0]  rts   [5] = '{5'd2, 5'd2, 5'd4, 5'd4, 5'd6};
    logic [15:0] imms  [5] = '{16'h1234, 16'hffff, 16'h00ff, 16'h0f0f, 16'h8000};
    logic [31:0] exps  [5] = '{32'h8C221234, 32'h1022FFFF, 32'h306400FF, 32'h34640F0F, 32'h28A68000};
    logic [31:0] w; logic [7:0] a0; int we; bit ct;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_fields(kinds[i], rss[i], rts[i], 5'd17, 5'd21, 6'h2a, imms[i], 26'h2aaaaaa);
      handshake();
      capture_word(w, a0, we, ct);
      n_checks++;
      if ({w, a0, we[2:0], ct} !== {exps[i], 8'(4 * i), 3'd4, 1'b1}) begin
        n_fail++;
        $display("FAIL kind_%0d: word=%h addr0=%h we_cycles=%0d contig=%b, required %h %h 4 1",
                 kinds[i], w, a0, we, ct, exps[i], 8'(4 * i));
      end
    end
  endtask

  task automatic test_jump_illegal();
    logic [31:0] w; logic [7:0] a0; int we; bit ct;
    do_reset();
    set_fields(4'd4, 5'd9, 5'd9, 5'd9, 5'd9, 6'h09, 16'h9999, 26'h0000010);
    handshake();
    capture_word(w, a0, we, ct);
    n_checks++;
    if ({w, a0, we[2:0], ct} !== {32'h08000010, 8'h00, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL jump_word: word=%h addr0=%h we_cycles=%0d contig=%b, required 08000010 00 4 1", w, a0, we, ct);
    end
    set_fields(4'd12, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'h0006, 26'h0000007);
    handshake();
    n_checks++;
    if ({mem_we, err, in_ready, word_count} !== {1'b0, 1'b1, 1'b1, 7'd1}) begin
      n_fail++;
      $display("FAIL illegal_kind: we=%b err=%b ready=%b cnt=%0d, required 0 1 1 1", mem_we, err, in_ready, word_count);
    end
    tick();
    n_checks++;
    if (mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_nowrite: we=%b required 0", mem_we);
    end
    set_fields(4'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0);
    handshake();
    capture_word(w, a0, we, ct);
    n_checks++;
    if ({w, a0, we[2:0], ct, err} !== {32'h20080005, 8'h04, 3'd4, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL after_illegal: word=%h addr0=%h we_cycles=%0d contig=%b err=%b, required 20080005 04 4 1 1",
               w, a0, we, ct, err);
    end
  endtask

  task automatic test_full_clear();
    logic [31:0] w; logic [7:0] a0; int we; bit ct; int bad = 0; int we_seen = 0;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      set_fields(4'd7, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'(i), 26'h0);
      handshake();
      capture_word(w, a0, we, ct);
      if ({w, a0, we[2:0], ct} !== {16'h3422, 16'(i), 8'(4 * i), 3'd4, 1'b1}) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL fill_words: %0d of 64 words wrong, required 0", bad);
    end
    n_checks++;
    if ({full, in_ready, word_count} !== {1'b1, 1'b0, 7'd64}) begin
      n_fail++;
      $display("FAIL full_state: full=%b ready=%b cnt=%0d, required 1 0 64", full, in_ready, word_count);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (mem_we === 1'b1) we_seen++;
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (we_seen != 0) begin
      n_fail++;
      $display("FAIL full_blocks: %0d write cycles while full, required 0", we_seen);
    end
    addr_clr = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_ready: in_ready=%b during addr_clr, required 0", in_ready);
    end
    tick();
    addr_clr = 1'b0;
    #1;
    n_checks++;
    if ({full, word_count, in_ready} !== {1'b0, 7'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL clr_state: full=%b cnt=%0d ready=%b, required 0 0 1", full, word_count, in_ready);
    end
    set_fields(4'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0);
    handshake();
    capture_word(w, a0, we, ct);
    n_checks++;
    if ({w, a0, we[2:0]} !== {32'h20080005, 8'h00, 3'd4}) begin
      n_fail++;
      $display("FAIL clr_next: word=%h addr0=%h we_cycles=%0d, required 20080005 00 4", w, a0, we);
    end
  endtask

  task automatic test_reset_midword();
    logic [31:0] w; logic [7:0] a0; int we; bit ct;
    do_reset();
    set_fields(4'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0);
    handshake();
    capture_word(w, a0, we, ct);
    set_fields(4'd2, 5'd29, 5'd9, 5'd0, 5'd0, 6'h00, 16'h0008, 26'h0);
    handshake();
    tick();
    tick();   // now in WR2 of the second word
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_we, word_count, mem_addr} !== {1'b0, 7'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid: we=%b cnt=%0d addr=%h, required 0 0 00", mem_we, word_count, mem_addr);
    end
    #2;
    rst_n = 1'b1;
    tick();
    handshake();
    capture_word(w, a0, we, ct);
    n_checks++;
    if ({w, a0, we[2:0], ct} !== {32'hAFA90008, 8'h00, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_next: word=%h addr0=%h we_cycles=%0d contig=%b, required afa90008 00 4 1", w, a0, we, ct);
    end
  endtask

  task automatic test_clr_during_write();
    logic [31:0] w; logic [7:0] a0; int we; bit ct;
    do_reset();
    set_fields(4'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0);
    handshake();
    capture_word(w, a0, we, ct);
    set_fields(4'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0000010);
    handshake();
    w = 32'h0; a0 = mem_addr; we = 0; ct = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (mem_we === 1'b1) we++;
      if (mem_addr !== a0 + 8'(i)) ct = 1'b0;
      w = {w[23:0], mem_wdata};
      addr_clr = (i == 1);   // high across the WR1 edge only
      tick();
    end
    addr_clr = 1'b0;
    n_checks++;
    if ({w, a0, we[2:0], ct, word_count} !== {32'h08000010, 8'h04, 3'd4, 1'b1, 7'd2}) begin
      n_fail++;
      $display("FAIL clr_in_wr1: word=%h addr0=%h we_cycles=%0d contig=%b cnt=%0d, required 08000010 04 4 1 2",
               w, a0, we, ct, word_count);
    end
    set_fields(4'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0);
    handshake();
    capture_word(w, a0, we, ct);
    n_checks++;
    if ({a0, word_count} !== {8'h08, 7'd3}) begin
      n_fail++;
      $display("FAIL clr_in_wr1_ptr: addr0=%h cnt=%0d, required 08 3", a0, word_count);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_kinds();
    test_jump_illegal();
    test_full_clear();
    test_reset_midword();
    test_clr_during_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
